// File: rtl/bcd_countdown_pkg.sv
// bcd_countdown_pkg: shared BCD widths, digit limit and FSM state encoding
package bcd_countdown_pkg;
    localparam int BCD_W = 4;
    localparam logic [BCD_W-1:0] BCD_MAX = 4'd9;
    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_HOLD} state_t;
endpackage

// File: rtl/bcd_countdown_if.sv
// bcd_countdown_if: control strobes in, BCD count and status flags out
interface bcd_countdown_if #(parameter int DIGITS = 2);
    logic                  load;
    logic [4*DIGITS-1:0]   load_val;
    logic                  start;
    logic                  pause;
    logic [4*DIGITS-1:0]   cnt;
    logic                  running;
    logic                  done;
    logic                  load_err;
    modport master (output load, load_val, start, pause, input cnt, running, done, load_err);
    modport slave  (input load, load_val, start, pause, output cnt, running, done, load_err);
endinterface

// File: rtl/bcd_countdown_digit.sv
// bcd_countdown_digit: one BCD digit that counts down and borrows from the next digit on 0 -> 9
module bcd_countdown_digit
    import bcd_countdown_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             ld,
    input  logic [BCD_W-1:0] ld_val,
    input  logic             dec,
    input  logic             borrow_in,
    output logic [BCD_W-1:0] q,
    output logic             borrow_out,
    output logic             is_zero
);
    assign is_zero    = (q == '0);
    assign borrow_out = dec & borrow_in & is_zero;
    // Preset clamps illegal digits to 0; a decrement at 0 wraps to 9 and borrows onward
    always_ff @(posedge clk or negedge rst)
        if (!rst)
            q <= '0;
        else if (ld)
            q <= (ld_val > BCD_MAX) ? '0 : ld_val;
        else if (dec & borrow_in)
            q <= is_zero ? BCD_MAX : q - 1'b1;
endmodule

// File: rtl/bcd_countdown.sv
// bcd_countdown: multi-digit BCD down-counter with prescaler, pause/resume and done pulse
module bcd_countdown
    import bcd_countdown_pkg::*;
#(
    parameter int DIGITS   = 2,
    parameter int TICK_DIV = 1
)(
    input  logic clk,
    input  logic rst,
    bcd_countdown_if.slave bus
);
    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    state_t              state;
    logic [PW-1:0]       pre;
    logic [DIGITS:0]     borrow;
    logic [DIGITS-1:0]   zero;
    logic [DIGITS-1:0]   bad;
    logic [4*DIGITS-1:0] cnt;
    logic                tick;
    logic                last;
    logic                running;
    logic                done;
    logic                load_err;
    assign tick      = (state == ST_RUN) && !bus.load && !bus.pause && (pre == PW'(TICK_DIV - 1));
    assign last      = tick && (cnt == (4*DIGITS)'(1));
    assign borrow[0] = tick;
    assign bus.cnt      = cnt;
    assign bus.running  = running;
    assign bus.done     = done;
    assign bus.load_err = load_err;
    genvar i;
    generate
        for (i = 0; i < DIGITS; i++) begin : g_dig
            assign bad[i] = bus.load_val[4*i +: 4] > BCD_MAX;
            bcd_countdown_digit u_dig (
                .clk        (clk),
                .rst        (rst),
                .ld         (bus.load),
                .ld_val     (bus.load_val[4*i +: 4]),
                .dec        (tick),
                .borrow_in  (borrow[i]),
                .q          (cnt[4*i +: 4]),
                .borrow_out (borrow[i+1]),
                .is_zero    (zero[i])
            );
        end
    endgenerate
    // Control FSM with prescaler; running/done/load_err are registered alongside the state
    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            state    <= ST_IDLE;
            pre      <= '0;
            running  <= 1'b0;
            done     <= 1'b0;
            load_err <= 1'b0;
        end else begin
            done     <= 1'b0;
            load_err <= 1'b0;
            if (bus.load) begin
                state    <= ST_IDLE;
                running  <= 1'b0;
                pre      <= '0;
                load_err <= |bad;
            end else begin
                case (state)
                    ST_IDLE:
                        if (bus.start && !bus.pause && !(&zero)) begin
                            state   <= ST_RUN;
                            running <= 1'b1;
                        end
                    ST_RUN:
                        if (bus.pause) begin
                            state   <= ST_HOLD;
                            running <= 1'b0;
                        end else if (tick) begin
                            pre <= '0;
                            // a borrow out of the top digit would be an underflow; stop there too
                            if (last || borrow[DIGITS]) begin
                                state   <= ST_IDLE;
                                running <= 1'b0;
                                done    <= 1'b1;
                            end
                        end else
                            pre <= pre + 1'b1;
                    ST_HOLD:
                        if (bus.start && !bus.pause) begin
                            state   <= ST_RUN;
                            running <= 1'b1;
                        end
                    default: begin
                        state   <= ST_IDLE;
                        running <= 1'b0;
                    end
                endcase
            end
        end
endmodule

// File: tb/tb_bcd_countdown.sv
// tb_bcd_countdown: two counters (TICK_DIV 1 and 4) against a decimal-integer reference model
module tb_bcd_countdown;
    localparam int D = 2;
    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         ld = 1'b0;
    logic [7:0]   lv = '0;
    logic         st = 1'b0;
    logic         ps = 1'b0;
    int           n_chk = 0;
    int           n_fail = 0;
    int           tdiv [2] = '{1, 4};
    int           m_val [2];
    int           m_pre [2];
    int           m_mode [2];
    bit           m_done [2];
    bit           m_err [2];

    bcd_countdown_if #(.DIGITS(D)) b1 ();
    bcd_countdown_if #(.DIGITS(D)) b4 ();

    assign b1.load = ld;
    assign b1.load_val = lv;
    assign b1.start = st;
    assign b1.pause = ps;
    assign b4.load = ld;
    assign b4.load_val = lv;
    assign b4.start = st;
    assign b4.pause = ps;

    bcd_countdown #(.DIGITS(D), .TICK_DIV(1)) dut1 (.clk(clk), .rst(rst), .bus(b1));
    bcd_countdown #(.DIGITS(D), .TICK_DIV(4)) dut4 (.clk(clk), .rst(rst), .bus(b4));

    always #5 clk = ~clk;

    function automatic logic [7:0] to_bcd(int v);
        return {4'(v / 10), 4'(v % 10)};
    endfunction

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_val[i] = 0; m_pre[i] = 0; m_mode[i] = 0; m_done[i] = 0; m_err[i] = 0;
        end
    endtask

    // mode: 0 idle, 1 counting, 2 held
    task automatic model_edge();
        for (int i = 0; i < 2; i++) begin
            m_done[i] = 0;
            m_err[i] = 0;
            if (ld) begin
                m_val[i] = 0;
                for (int k = 0; k < D; k++) begin
                    int d;
                    d = int'(lv[4*k +: 4]);
                    if (d > 9) m_err[i] = 1;
                    else m_val[i] += d * (k == 0 ? 1 : 10);
                end
                m_mode[i] = 0;
                m_pre[i] = 0;
            end else if (m_mode[i] == 0) begin
                if (st && !ps && m_val[i] != 0) m_mode[i] = 1;
            end else if (m_mode[i] == 1) begin
                if (ps) m_mode[i] = 2;
                else if (m_pre[i] == tdiv[i] - 1) begin
                    m_pre[i] = 0;
                    m_val[i]--;
                    if (m_val[i] == 0) begin
                        m_mode[i] = 0;
                        m_done[i] = 1;
                    end
                end else m_pre[i]++;
            end else if (st && !ps) m_mode[i] = 1;
        end
    endtask

    task automatic compare_all();
        check("cnt_td1", b1.cnt, to_bcd(m_val[0]));
        check("running_td1", b1.running, m_mode[0] == 1);
        check("done_td1", b1.done, m_done[0]);
        check("load_err_td1", b1.load_err, m_err[0]);
        check("cnt_td4", b4.cnt, to_bcd(m_val[1]));
        check("running_td4", b4.running, m_mode[1] == 1);
        check("done_td4", b4.done, m_done[1]);
        check("load_err_td4", b4.load_err, m_err[1]);
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        compare_all();
    endtask

    task automatic drive(logic l, logic [7:0] v, logic s, logic p, int n);
        ld = l; lv = v; st = s; ps = p;
        step();
        ld = 0; st = 0; ps = 0;
        for (int k = 1; k < n; k++) step();
    endtask

    initial begin
        model_reset();
        #2;
        compare_all();
        #10 rst = 1'b1;
        step();
        // count down 12 to 0 with done at 00
        drive(1, 8'h12, 0, 0, 1);
        drive(0, 8'h00, 1, 0, 50);
        // borrow 10 -> 09, then start on zero ignored
        drive(1, 8'h10, 0, 0, 1);
        drive(0, 8'h00, 1, 0, 3);
        drive(1, 8'h00, 0, 0, 1);
        drive(0, 8'h00, 1, 0, 4);
        // prescaled countdown from 03
        drive(1, 8'h03, 0, 0, 1);
        drive(0, 8'h00, 1, 0, 16);
        // pause/hold/resume, then pause&start while counting
        drive(1, 8'h05, 0, 0, 1);
        drive(0, 8'h00, 1, 0, 2);
        drive(0, 8'h00, 0, 1, 10);
        drive(0, 8'h00, 1, 1, 3);
        drive(0, 8'h00, 1, 0, 3);
        drive(0, 8'h00, 1, 1, 2);
        drive(0, 8'h00, 1, 0, 30);
        // load priority and illegal digit clamping
        drive(1, 8'h45, 0, 0, 1);
        drive(0, 8'h00, 1, 0, 3);
        drive(1, 8'h1A, 1, 0, 3);
        drive(0, 8'h00, 1, 0, 2);
        drive(1, 8'hB7, 0, 1, 3);
        // async reset mid-run at 37
        drive(1, 8'h40, 0, 0, 1);
        drive(0, 8'h00, 1, 0, 4);
        check("pre_reset_cnt", b1.cnt, 8'h37);
        #1 rst = 1'b0;
        #1 model_reset();
        compare_all();
        #1 rst = 1'b1;
        step();
        // random traffic
        for (int c = 0; c < 3000; c++) begin
            ld = ($urandom_range(0, 39) == 0);
            lv = 8'($urandom);
            st = ($urandom_range(0, 3) == 0);
            ps = ($urandom_range(0, 9) == 0);
            step();
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
